sync_fifo_checker: RTL

Synthesisable, parametrised single-clock FIFO checker: the next generation of our async-FIFO assertion interface, with a cycle-accurate reference model instead of fixed-depth properties. It observes a FIFO's push/pop handshake, flags and read data, and keeps a shadow occupancy count and data store. It reports flag mismatches, data corruption and rejected accesses as sticky error bits plus saturating counters. It is bound beside the FIFO under test in simulation and emulation, and is readable by the testbench scoreboard.

---
 rtl/sync_fifo_checker.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sync_fifo_checker.sv
// Single-clock FIFO checker: shadow occupancy/data model of a FIFO under test,
// flag and read-data comparison, sticky error capture and saturating statistics.
module sync_fifo_checker #(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 4,
  parameter int AF_LEVEL = (1 << ASIZE) - 2,
  parameter int AE_LEVEL = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chk_en,
  input  logic             clr,
  input  logic             winc,
  input  logic             rinc,
  input  logic [DSIZE-1:0] wdata,
  input  logic [DSIZE-1:0] rdata,
  input  logic             wfull,
  input  logic             rempty,
  output logic [ASIZE:0]   count,
  output logic             exp_full,
  output logic             exp_empty,
  output logic             exp_afull,
  output logic             exp_aempty,
  output logic [3:0]       err_flags,
  output logic             err_pulse,
  output logic [2:0]       first_err,
  output logic [CNT_W-1:0] wdrop_cnt,
  output logic [CNT_W-1:0] rdrop_cnt,
  output logic [CNT_W-1:0] mism_cnt
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_C = (ASIZE + 1)'(DEPTH);

  logic [DSIZE-1:0] shadow [DEPTH];
  logic [ASIZE-1:0] wptr, rptr;
  logic [DSIZE-1:0] exp_rdata;
  logic             cmp_pend;

  logic       push_acc, pop_acc;
  logic [3:0] ev;
  logic [2:0] ev_code;
  logic [1:0] mism_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, base} + {{(CNT_W - 1){1'b0}}, inc};
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  assign push_acc = winc && !wfull;
  assign pop_acc  = rinc && !rempty;

  assign exp_full   = (count == DEPTH_C);
  assign exp_empty  = (count == '0);
  assign exp_afull  = (int'(count) >= AF_LEVEL);
  assign exp_aempty = (int'(count) <= AE_LEVEL);

  always_comb begin
    ev = '0;
    if (chk_en) begin
      ev[0] = (wfull != exp_full);
      ev[1] = (rempty != exp_empty);
      ev[2] = cmp_pend && (rdata != exp_rdata);
    end
    // Model integrity is tracked regardless of chk_en, like the model itself.
    ev[3] = (push_acc && !pop_acc && exp_full) || (pop_acc && !push_acc && exp_empty);
  end

  always_comb begin
    ev_code = 3'd0;
    if (ev[0])      ev_code = 3'd1;
    else if (ev[1]) ev_code = 3'd2;
    else if (ev[2]) ev_code = 3'd3;
    else if (ev[3]) ev_code = 3'd4;
  end

  assign mism_inc = {1'b0, ev[0]} + {1'b0, ev[1]} + {1'b0, ev[2]};

  // Shadow contents are don't-care after reset, so the store has no reset.
  always_ff @(posedge clk) begin
    if (push_acc) shadow[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr      <= '0;
      rptr      <= '0;
      exp_rdata <= '0;
      cmp_pend  <= 1'b0;
      count     <= '0;
    end else begin
      if (push_acc) wptr <= wptr + ASIZE'(1);
      if (pop_acc) begin
        rptr      <= rptr + ASIZE'(1);
        exp_rdata <= shadow[rptr];
      end
      cmp_pend <= pop_acc;
      if (push_acc && !pop_acc) begin
        if (!exp_full) count <= count + (ASIZE + 1)'(1);
      end else if (pop_acc && !push_acc) begin
        if (!exp_empty) count <= count - (ASIZE + 1)'(1);
      end
    end
  end

  // Error capture: clr clears, but an event in the same cycle still lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_flags <= '0;
      err_pulse <= 1'b0;
      first_err <= '0;
      wdrop_cnt <= '0;
      rdrop_cnt <= '0;
      mism_cnt  <= '0;
    end else begin
      err_flags <= (clr ? 4'b0000 : err_flags) | ev;
      err_pulse <= |ev;
      if ((ev_code != 3'd0) && (clr || (first_err == 3'd0))) first_err <= ev_code;
      else if (clr)                                           first_err <= '0;
      wdrop_cnt <= sat_add(clr ? '0 : wdrop_cnt, {1'b0, winc && wfull});
      rdrop_cnt <= sat_add(clr ? '0 : rdrop_cnt, {1'b0, rinc && rempty});
      mism_cnt  <= sat_add(clr ? '0 : mism_cnt, mism_inc);
    end
  end

endmodule
